// File: rtl/led_trail_pwm_pkg.sv
// Shared defaults and helpers for the LED trail PWM block.
// Holds the channel-count, level-width and decay defaults. It also provides
// the one-hot check and index encoder used on the registered head pattern.
package led_trail_pwm_pkg;

    localparam int unsigned N_DEF     = 10;
    localparam int unsigned LW_DEF    = 4;
    localparam int unsigned LMAX_DEF  = (1 << LW_DEF) - 1;
    localparam int unsigned DECAY_DEF = 3;

    // head_idx is 4 bits wide, so patterns of up to 16 channels can be encoded
    localparam int unsigned IDX_W = 4;
    localparam int unsigned VEC_W = 1 << IDX_W;

    // True when exactly one bit is set
    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
    endfunction

    // Binary index of the set bit; only meaningful for a one-hot input
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [VEC_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// Pattern/control inputs and LED/status outputs of the LED trail PWM block.
// The master modport drives pattern, step and trail_en and observes the outputs.
// The slave modport is the view used by the block itself.
interface led_trail_pwm_if
    import led_trail_pwm_pkg::*;
#(
    parameter int unsigned N = N_DEF
);
    logic [N-1:0]     pattern;
    logic             step;
    logic             trail_en;
    logic [N-1:0]     led;
    logic [IDX_W-1:0] head_idx;
    logic             err;

    modport master (
        output pattern, step, trail_en,
        input  led, head_idx, err
    );

    modport slave (
        input  pattern, step, trail_en,
        output led, head_idx, err
    );
endinterface

// File: rtl/led_trail_chan.sv
// One LED channel of the trail: a level register and a registered PWM compare.
// Ports: clk, rst_n (sync, active low), load (head on this channel), trail_en,
//        step, pwm_cnt (shared counter), led (registered PWM drive).
module led_trail_chan
    import led_trail_pwm_pkg::*;
#(
    parameter int unsigned LW    = LW_DEF,
    parameter int unsigned LMAX  = LMAX_DEF,
    parameter int unsigned DECAY = DECAY_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          trail_en,
    input  logic          step,
    input  logic [LW-1:0] pwm_cnt,
    output logic          led
);
    logic [LW-1:0] lvl;
    logic [LW-1:0] lvl_dec_c;

    // Saturating decrement; the compare runs at 32 bits, so a DECAY wider than LW is safe
    always_comb begin
        lvl_dec_c = '0;
        if (32'(lvl) >= DECAY) lvl_dec_c = lvl - LW'(DECAY);
    end

    // Head load wins; otherwise clear, decay or hold. The LED samples the pre-edge level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl <= '0;
            led <= 1'b0;
        end else begin
            led <= (pwm_cnt < lvl);
            if (load)          lvl <= LW'(LMAX);
            else if (!trail_en) lvl <= '0;
            else if (step)      lvl <= lvl_dec_c;
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// PWM-dimmed LED trail that follows a one-hot bouncing head position.
// Ports: clk, rst_n (sync, active low), bus (slave view: pattern, step, trail_en in;
//        led, head_idx, err out).
// Top-level state: the registered pattern, the shared PWM counter, head_idx and
// the sticky err flag. Per-channel levels live in led_trail_chan.
module led_trail_pwm
    import led_trail_pwm_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LW    = LW_DEF,
    parameter int unsigned DECAY = DECAY_DEF
)(
    input  logic           clk,
    input  logic           rst_n,
    led_trail_pwm_if.slave bus
);
    localparam int unsigned LMAX = (1 << LW) - 1;

    logic [N-1:0]     pat_q;
    logic [LW-1:0]    pwm_cnt;
    logic [IDX_W-1:0] head_idx_q;
    logic             err_q;

    logic             onehot_c;
    logic [IDX_W-1:0] idx_c;
    logic [N-1:0]     load_c;
    logic [N-1:0]     led_w;

    // Classify the registered pattern; an invalid pattern loads no channel
    always_comb begin
        onehot_c = is_onehot(VEC_W'(pat_q));
        idx_c    = onehot_idx(VEC_W'(pat_q));
        load_c   = onehot_c ? pat_q : '0;
    end

    // Pattern register, PWM counter (period LMAX), head index and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q      <= N'(1);
            pwm_cnt    <= '0;
            head_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pat_q   <= bus.pattern;
            pwm_cnt <= (pwm_cnt == LW'(LMAX - 1)) ? '0 : pwm_cnt + LW'(1);
            if (onehot_c) head_idx_q <= idx_c;
            else          err_q      <= 1'b1;
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_chan
        led_trail_chan #(
            .LW    (LW),
            .LMAX  (LMAX),
            .DECAY (DECAY)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_c[i]),
            .trail_en (bus.trail_en),
            .step     (bus.step),
            .pwm_cnt  (pwm_cnt),
            .led      (led_w[i])
        );
    end

    assign bus.led      = led_w;
    assign bus.head_idx = head_idx_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: the driver pushes expected outputs per cycle,
// and the monitor pops and compares them one time unit after each rising edge.
module tb_led_trail_pwm;
    localparam int unsigned NCH = 10;

    typedef struct packed {
        logic [NCH-1:0] led;
        logic [3:0]     head;
        logic           err;
        logic           ws;    // start a led[0] duty window at this sample
        logic           we;    // close the window and compare the duty here
        logic [31:0]    duty;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state, updated once per driven edge
    logic [NCH-1:0] m_pat;
    logic [NCH-1:0] m_led;
    int             m_lvl[NCH];
    int             m_pwm;
    int             m_head;
    logic           m_err;

    int duty_tab[6] = '{12, 9, 6, 3, 0, 0};

    led_trail_pwm_if #(.N(NCH)) bus();

    led_trail_pwm #(.N(NCH), .LW(4), .DECAY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [NCH-1:0] pat, input logic stp, input logic te,
                              input logic rn);
        logic one;
        if (!rn) begin
            m_pat  = NCH'(1);
            m_pwm  = 0;
            m_head = 0;
            m_err  = 1'b0;
            m_led  = '0;
            for (int i = 0; i < int'(NCH); i++) m_lvl[i] = 0;
        end else begin
            one = ($countones(m_pat) == 1);
            for (int i = 0; i < int'(NCH); i++) m_led[i] = (m_pwm < m_lvl[i]);
            for (int i = 0; i < int'(NCH); i++) begin
                if (one && m_pat[i]) m_lvl[i] = 15;
                else if (!te)        m_lvl[i] = 0;
                else if (stp)        m_lvl[i] = (m_lvl[i] > 3) ? m_lvl[i] - 3 : 0;
            end
            if (one) begin
                for (int i = 0; i < int'(NCH); i++) if (m_pat[i]) m_head = i;
            end else begin
                m_err = 1'b1;
            end
            m_pwm = (m_pwm == 14) ? 0 : m_pwm + 1;
            m_pat = pat;
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] pat, input logic stp, input logic te,
                       input logic rn, input logic ws, input logic we, input int duty);
        exp_t e;
        @(negedge clk);
        bus.pattern  = pat;
        bus.step     = stp;
        bus.trail_en = te;
        rst_n        = rn;
        model_edge(pat, stp, te, rn);
        e.led  = m_led;
        e.head = 4'(m_head);
        e.err  = m_err;
        e.ws   = ws;
        e.we   = we;
        e.duty = 32'(duty);
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [NCH-1:0] pat, input logic stp, input logic te, input int n);
        for (int k = 0; k < n; k++) cyc(pat, stp, te, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: compare every presented sample against the scoreboard head
    initial begin
        exp_t e;
        int   cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.led !== e.led) begin
                    errors++;
                    $display("FAIL led t=%0t got %b want %b", $time, bus.led, e.led);
                end
                checks++;
                if (bus.head_idx !== e.head) begin
                    errors++;
                    $display("FAIL head_idx t=%0t got %0d want %0d", $time, bus.head_idx, e.head);
                end
                checks++;
                if (bus.err !== e.err) begin
                    errors++;
                    $display("FAIL err t=%0t got %b want %b", $time, bus.err, e.err);
                end
                if (e.ws) cnt = 0;
                if (bus.led[0] === 1'b1) cnt++;
                if (e.we) begin
                    checks++;
                    if (cnt != int'(e.duty)) begin
                        errors++;
                        $display("FAIL duty0 t=%0t got %0d want %0d", $time, cnt, e.duty);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int d;
        int pos;
        bus.pattern  = NCH'(1);
        bus.step     = 1'b0;
        bus.trail_en = 1'b1;

        // Reset, then a static head on bit 0
        repeat (2) cyc(NCH'(1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(NCH'(1), 1'b0, 1'b1, 20);

        // Head moves to bit 1; channel 0 decays by 3 every 15 clocks
        cyc(NCH'(2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int t = 0; t <= 90; t++) begin
            d = (t > 0) ? duty_tab[(t / 15) - 1] : 0;
            cyc(NCH'(2), (t % 15 == 0) && (t < 90), 1'b1, 1'b1,
                (t % 15 == 1) && (t < 90), (t > 0) && (t % 15 == 0), d);
        end

        // Head-only mode, bouncing 0..9..0
        for (int s = 0; s < 19; s++) begin
            pos = (s < 10) ? s : 18 - s;
            run(NCH'(1) << pos, 1'b0, 1'b0, 2);
        end

        // Trail with step coincident with the head arriving on each channel
        for (int p = 0; p < 5; p++) begin
            cyc(NCH'(1) << p, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            cyc(NCH'(1) << p, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            cyc(NCH'(1) << p, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        end
        run(NCH'(1) << 4, 1'b0, 1'b1, 16);

        // trail_en toggled mid-trail, then a new trail builds up
        run(NCH'(1) << 4, 1'b0, 1'b0, 2);
        for (int p = 5; p < 9; p++) begin
            cyc(NCH'(1) << p, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            run(NCH'(1) << p, 1'b0, 1'b1, 3);
        end

        // Reset for a single edge mid-trail
        cyc(NCH'(1) << 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(NCH'(1) << 8, 1'b0, 1'b1, 6);

        // Zero pattern for one cycle, then multi-hot; err must stick and head_idx hold
        cyc(NCH'(0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run(NCH'(1) << 3, 1'b1, 1'b1, 4);
        cyc(NCH'(3), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run(NCH'(1) << 9, 1'b0, 1'b1, 18);

        // Reset clears the sticky error
        cyc(NCH'(1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(NCH'(1), 1'b0, 1'b1, 4);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
